mat_mult_ctrl: RTL and testbench

Sequencer that drives and drains the 4x4 output-stationary systolic PE array. It holds the A and B operand matrices (4x4, 8-bit) in local buffers loaded over a simple write port. On `start` it clears the array accumulators, streams the columns of A and rows of B into the array's edge ports, and flushes the pipeline. It then walks the array's result select and emits the 16 32-bit elements of C = A x B on a valid/ready stream.

---
 rtl/mat_mult_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mat_mult_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_ctrl.sv
// mat_mult_ctrl: operand buffers and sequencer for a 4x4 output-stationary
// systolic PE array. Clears, feeds, flushes, then drains C row-major.
module mat_mult_ctrl #(
    parameter int FLUSH_CYCLES = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] c_data,
    output logic        c_valid,
    input  logic        c_ready,
    output logic        c_last,
    output logic        pe_en,
    output logic        pe_clr_n,
    output logic [7:0]  pe_data0,
    output logic [7:0]  pe_data1,
    output logic [7:0]  pe_data2,
    output logic [7:0]  pe_data3,
    output logic [7:0]  pe_weight0,
    output logic [7:0]  pe_weight1,
    output logic [7:0]  pe_weight2,
    output logic [7:0]  pe_weight3,
    output logic [3:0]  pe_out_sel,
    input  logic [31:0] pe_result
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } state_t;

    localparam logic [7:0] FLUSH_N = 8'(FLUSH_CYCLES);

    state_t          state;
    logic [7:0]      cnt;
    logic [4:0]      idx;
    logic [4:0]      idx_n;
    logic [1:0]      kk;
    logic [7:0]      a_buf [16];
    logic [7:0]      b_buf [16];
    logic [3:0][7:0] dat_q;
    logic [3:0][7:0] wgt_q;
    logic [3:0][7:0] fa;
    logic [3:0][7:0] fb;

    assign pe_data0   = dat_q[0];
    assign pe_data1   = dat_q[1];
    assign pe_data2   = dat_q[2];
    assign pe_data3   = dat_q[3];
    assign pe_weight0 = wgt_q[0];
    assign pe_weight1 = wgt_q[1];
    assign pe_weight2 = wgt_q[2];
    assign pe_weight3 = wgt_q[3];

    assign idx_n = idx + 5'd1;

    // Column k of A and row k of B for the next feed beat (k = 0 from CLEAR).
    always_comb begin
        kk = (state == FEED) ? cnt[1:0] : 2'd0;
        for (int i = 0; i < 4; i++) begin
            fa[i] = a_buf[{i[1:0], kk}];
            fb[i] = b_buf[{kk, i[1:0]}];
        end
    end

    // Operand buffers accept writes only while no job is running.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (a_we) a_buf[wr_addr] <= wr_data;
            if (b_we) b_buf[wr_addr] <= wr_data;
        end
    end

    // Job sequencer: clear, feed, flush, then drain results with handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            c_data     <= '0;
            c_valid    <= 1'b0;
            c_last     <= 1'b0;
            pe_en      <= 1'b0;
            pe_clr_n   <= 1'b1;
            dat_q      <= '0;
            wgt_q      <= '0;
            pe_out_sel <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        pe_clr_n <= 1'b0;
                    end
                end
                CLEAR: begin
                    state    <= FEED;
                    pe_clr_n <= 1'b1;
                    pe_en    <= 1'b1;
                    dat_q    <= fa;
                    wgt_q    <= fb;
                    cnt      <= 8'd1;
                end
                FEED: begin
                    if (cnt == 8'd4) begin
                        state <= FLUSH;
                        dat_q <= '0;
                        wgt_q <= '0;
                        cnt   <= 8'd1;
                    end else begin
                        dat_q <= fa;
                        wgt_q <= fb;
                        cnt   <= cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    if (cnt == FLUSH_N) begin
                        state      <= DRAIN;
                        pe_en      <= 1'b0;
                        pe_out_sel <= '0;
                        idx        <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    if (c_valid && c_ready && c_last) begin
                        state      <= IDLE;
                        c_valid    <= 1'b0;
                        c_last     <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pe_out_sel <= '0;
                    end else if (!idx[4] && (!c_valid || c_ready)) begin
                        c_data     <= pe_result;
                        c_valid    <= 1'b1;
                        c_last     <= (idx == 5'd15);
                        idx        <= idx_n;
                        pe_out_sel <= {idx_n[1:0], idx_n[3:2]};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mult_ctrl.sv
// tb_mat_mult_ctrl: drives jobs into mat_mult_ctrl backed by a skewed
// 4x4 output-stationary array model and scoreboards the result stream.
module tb_mat_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_we, b_we;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        start;
    logic        busy, done;
    logic [31:0] c_data;
    logic        c_valid, c_ready, c_last;
    logic        pe_en, pe_clr_n;
    logic [7:0]  pe_data0, pe_data1, pe_data2, pe_data3;
    logic [7:0]  pe_weight0, pe_weight1, pe_weight2, pe_weight3;
    logic [3:0]  pe_out_sel;
    logic [31:0] pe_result;

    always #5 clk = ~clk;

    mat_mult_ctrl #(.FLUSH_CYCLES(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_we(a_we), .b_we(b_we),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done),
        .c_data(c_data), .c_valid(c_valid),
        .c_ready(c_ready), .c_last(c_last),
        .pe_en(pe_en), .pe_clr_n(pe_clr_n),
        .pe_data0(pe_data0), .pe_data1(pe_data1),
        .pe_data2(pe_data2), .pe_data3(pe_data3),
        .pe_weight0(pe_weight0), .pe_weight1(pe_weight1),
        .pe_weight2(pe_weight2), .pe_weight3(pe_weight3),
        .pe_out_sel(pe_out_sel), .pe_result(pe_result)
    );

    // ---------------- systolic array model ----------------
    logic [7:0]  pd [4];
    logic [7:0]  pw [4];
    logic [7:0]  ain [4];
    logic [7:0]  bin [4];
    logic [7:0]  dsk [4][3];
    logic [7:0]  wsk [4][3];
    logic [7:0]  ar [4][4];
    logic [7:0]  br [4][4];
    logic [31:0] acc [4][4];
    logic [7:0]  av, bv;

    assign pd[0] = pe_data0;
    assign pd[1] = pe_data1;
    assign pd[2] = pe_data2;
    assign pd[3] = pe_data3;
    assign pw[0] = pe_weight0;
    assign pw[1] = pe_weight1;
    assign pw[2] = pe_weight2;
    assign pw[3] = pe_weight3;

    assign ain[0] = pd[0];
    assign ain[1] = dsk[1][0];
    assign ain[2] = dsk[2][1];
    assign ain[3] = dsk[3][2];
    assign bin[0] = pw[0];
    assign bin[1] = wsk[1][0];
    assign bin[2] = wsk[2][1];
    assign bin[3] = wsk[3][2];

    assign pe_result = acc[pe_out_sel[1:0]][pe_out_sel[3:2]];

    always @(posedge clk) begin
        if (!pe_clr_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int d = 0; d < 3; d++) begin
                    dsk[i][d] <= '0;
                    wsk[i][d] <= '0;
                end
                for (int j = 0; j < 4; j++) begin
                    acc[i][j] <= '0;
                    ar[i][j]  <= '0;
                    br[i][j]  <= '0;
                end
            end
        end else if (pe_en) begin
            for (int i = 0; i < 4; i++) begin
                dsk[i][0] <= pd[i];
                wsk[i][0] <= pw[i];
                for (int d = 1; d < 3; d++) begin
                    dsk[i][d] <= dsk[i][d-1];
                    wsk[i][d] <= wsk[i][d-1];
                end
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (j == 0) av = ain[i];
                    else        av = ar[i][j-1];
                    if (i == 0) bv = bin[j];
                    else        bv = br[i-1][j];
                    ar[i][j]  <= av;
                    br[i][j]  <= bv;
                    acc[i][j] <= acc[i][j] + 32'(av) * 32'(bv);
                end
            end
        end
    end

    // ---------------- bench state ----------------
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          t_start = 0;
    int          first_lat = 0;
    bit          seen_valid = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    bit          rnd = 0;
    logic [7:0]  sa [16];
    logic [7:0]  sb [16];
    logic [31:0] exp_q [$];
    bit          last_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // c_ready source: held high or toggled randomly
    initial begin
        c_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            c_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // output monitor: a beat is a handshake seen ahead of the next edge
    always @(negedge clk) begin
        logic [31:0] e;
        bit          l;
        if (done) done_cnt++;
        if (rst_n && c_valid && !seen_valid) begin
            first_lat  = cyc + 1 - t_start;
            seen_valid = 1;
        end
        if (rst_n && c_valid && c_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", c_data, 32'hffff_ffff);
            end else begin
                e = exp_q.pop_front();
                l = last_q.pop_front();
                chk("c_data", c_data, e);
                chk("c_last", 32'(c_last), 32'(l));
            end
        end
    end

    task automatic push_exp();
        logic [31:0] s;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = '0;
                for (int k = 0; k < 4; k++)
                    s += 32'(sa[r*4+k]) * 32'(sb[k*4+c]);
                exp_q.push_back(s);
                last_q.push_back(r == 3 && c == 3);
            end
        end
    endtask

    task automatic wr(input bit is_b, input int addr, input logic [7:0] d);
        a_we    = !is_b;
        b_we    = is_b;
        wr_addr = 4'(addr);
        wr_data = d;
        if (is_b) sb[addr] = d;
        else      sa[addr] = d;
        @(posedge clk);
        #1;
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic wr_both(input int addr, input logic [7:0] d);
        a_we     = 1'b1;
        b_we     = 1'b1;
        wr_addr  = 4'(addr);
        wr_data  = d;
        sa[addr] = d;
        sb[addr] = d;
        @(posedge clk);
        #1;
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        push_exp();
        t_start    = cyc + 1;
        seen_valid = 0;
        hs_cnt     = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_we  = 1'b0;
        b_we  = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        chk("clr_pulse", 32'(pe_clr_n), 0);
        chk("en_in_clear", 32'(pe_en), 0);
    endtask

    task automatic wait_done(input int exp_lat);
        int n   = 0;
        bit got = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        chk("done_seen", 32'(got), 1);
        if (exp_lat != 0) chk("done_lat", cyc + 1 - t_start, exp_lat);
        chk("first_valid", first_lat, 14);
        chk("beats", hs_cnt, 16);
        chk("q_empty", exp_q.size(), 0);
        chk("busy_fall", 32'(busy), 0);
    endtask

    initial begin
        int n;
        int dc;
        rst_n   = 1'b0;
        a_we    = 1'b0;
        b_we    = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(c_valid), 0);
        chk("rst_last", 32'(c_last), 0);
        chk("rst_en", 32'(pe_en), 0);
        chk("rst_clr_n", 32'(pe_clr_n), 1);
        chk("rst_cdata", c_data, 0);
        chk("rst_sel", 32'(pe_out_sel), 0);
        chk("rst_data", {pe_data0, pe_data1, pe_data2, pe_data3}, 0);
        chk("rst_wgt", {pe_weight0, pe_weight1, pe_weight2, pe_weight3}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // identity x B
        for (int i = 0; i < 16; i++) begin
            wr(0, i, (i / 4 == i % 4) ? 8'd1 : 8'd0);
            wr(1, i, 8'(i));
        end
        kick();
        wait_done(30);

        // all 255, then a second job started in the done cycle
        for (int i = 0; i < 16; i++) wr_both(i, 8'd255);
        kick();
        wait_done(30);
        kick();
        wait_done(30);
        @(posedge clk);
        #1;

        // (r+1)(c+1)*4 with random back-pressure; last write rides on start
        for (int i = 0; i < 16; i++) wr(0, i, 8'(i / 4 + 1));
        for (int i = 0; i < 15; i++) wr(1, i, 8'(i % 4 + 1));
        rnd     = 1;
        b_we    = 1'b1;
        wr_addr = 4'd15;
        wr_data = 8'd4;
        sb[15]  = 8'd4;
        kick();
        wait_done(0);
        rnd = 0;
        @(posedge clk);
        #1;

        // identity x B, then zero A
        for (int i = 0; i < 16; i++) begin
            wr(0, i, (i / 4 == i % 4) ? 8'd1 : 8'd0);
            wr(1, i, 8'(i));
        end
        kick();
        wait_done(30);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) wr(0, i, 8'd0);
        kick();
        wait_done(30);
        @(posedge clk);
        #1;

        // start and a_we during FEED are ignored
        for (int i = 0; i < 16; i++) wr(0, i, (i / 4 == i % 4) ? 8'd1 : 8'd0);
        kick();
        @(posedge clk);
        #1;
        start   = 1'b1;
        a_we    = 1'b1;
        wr_addr = 4'd0;
        wr_data = 8'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_we  = 1'b0;
        chk("busy_feed", 32'(busy), 1);
        wait_done(30);
        @(posedge clk);
        #1;
        kick();
        wait_done(30);
        @(posedge clk);
        #1;

        // reset during DRAIN after 5 beats
        kick();
        n = 0;
        while (hs_cnt < 5 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_beats", hs_cnt, 5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        last_q.delete();
        dc = done_cnt;
        chk("mid_rst_valid", 32'(c_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_en", 32'(pe_en), 0);
        chk("mid_rst_last", 32'(c_last), 0);
        chk("mid_rst_clr_n", 32'(pe_clr_n), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("no_done", done_cnt, dc);
        chk("idle_valid", 32'(c_valid), 0);
        kick();
        wait_done(30);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
